// File: rtl/fetch_stage.sv
// Instruction fetch stage: keeps the fetch PC, issues in-order pipelined reads to
// instruction memory and buffers returned words with their PC for decode.
module fetch_stage #(
  parameter int              PC_W     = 36,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              f_valid,
  output logic [INST_W-1:0] f_inst,
  output logic [PC_W-1:0]   f_pc,
  output logic [PC_W-1:0]   f_pc_plus_4,
  input  logic              d_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc4;
  } entry_t;

  logic [PC_W-1:0]  fetch_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] drop_cnt;
  logic             rst_p1;

  logic [PC_W-1:0]  pend_pc [DEPTH];
  logic [PTR_W-1:0] pend_wr;
  logic [PTR_W-1:0] pend_rd;

  entry_t fq      [DEPTH];
  entry_t fq_next [DEPTH];
  entry_t new_entry;

  logic [CNT_W:0]   inflight;
  logic             accept;
  logic             drop_resp;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] outstanding_next;
  logic [CNT_W-1:0] drop_next;
  logic [CNT_W-1:0] cnt_after_pop;
  logic [CNT_W-1:0] cnt_next;

  // Request side: credit covers both in-flight reads and buffered words
  assign inflight       = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid = !rst && !rst_p1 && (inflight < (CNT_W+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign drop_resp = imem_resp_valid && (drop_cnt != '0);
  assign push      = imem_resp_valid && (drop_cnt == '0) && !redirect_valid;
  assign pop       = f_valid && d_ready && !redirect_valid;

  assign new_entry.inst = imem_resp_data;
  assign new_entry.pc   = pend_pc[pend_rd];
  assign new_entry.pc4  = pend_pc[pend_rd] + PC_W'(4);

  assign f_inst      = fq[0].inst;
  assign f_pc        = fq[0].pc;
  assign f_pc_plus_4 = fq[0].pc4;

  always_comb begin
    outstanding_next = outstanding + CNT_W'(accept) - CNT_W'(imem_resp_valid);
    drop_next        = drop_cnt;
    // Every read still in flight after a redirect is stale; outstanding already
    // includes the ones marked by earlier redirects, so it is the new drop count.
    if (redirect_valid) begin
      drop_next = outstanding_next;
    end else if (drop_resp) begin
      drop_next = drop_cnt - CNT_W'(1);
    end
  end

  // Output buffer: shift register so the head is always entry 0
  always_comb begin
    cnt_after_pop = pop ? fifo_count - CNT_W'(1) : fifo_count;
    for (int i = 0; i < DEPTH; i++) begin
      fq_next[i] = (pop && (i < DEPTH - 1)) ? fq[(i + 1) % DEPTH] : fq[i];
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == cnt_after_pop) fq_next[i] = new_entry;
      end
    end
    cnt_next = push ? cnt_after_pop + CNT_W'(1) : cnt_after_pop;
    if (redirect_valid) cnt_next = '0;
  end

  always_ff @(posedge clk) begin
    rst_p1 <= rst;
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      fifo_count  <= '0;
      drop_cnt    <= '0;
      pend_wr     <= '0;
      pend_rd     <= '0;
      f_valid     <= 1'b0;
    end else begin
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~PC_W'(3);
      end else if (accept) begin
        fetch_pc <= fetch_pc + PC_W'(4);
      end
      outstanding <= outstanding_next;
      fifo_count  <= cnt_next;
      drop_cnt    <= drop_next;
      f_valid     <= (cnt_next != '0);
      if (accept)          pend_wr <= pend_wr + PTR_W'(1);
      if (imem_resp_valid) pend_rd <= pend_rd + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pend_pc[pend_wr] <= fetch_pc;
  end

  // Head entry feeds the f_* outputs, which must read zero out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) fq[i] <= '0;
    end else begin
      fq <= fq_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_resp_valid && (outstanding == '0)))
        else $error("fetch_stage: memory response with no request outstanding");
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: in-order memory model with programmable latency,
// plus a second instance with a wrapping reset PC.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [35:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [35:0] redirect_pc;
  logic        f_valid;
  logic [31:0] f_inst;
  logic [35:0] f_pc;
  logic [35:0] f_pc_plus_4;
  logic        d_ready;

  logic        w_req_valid;
  logic        w_req_ready;
  logic [35:0] w_req_addr;
  logic        w_resp_valid;
  logic [31:0] w_resp_data;
  logic        w_redirect_valid;
  logic [35:0] w_redirect_pc;
  logic        w_f_valid;
  logic [31:0] w_f_inst;
  logic [35:0] w_f_pc;
  logic [35:0] w_f_pc_plus_4;
  logic        w_d_ready;
  logic        w_pend;
  logic [35:0] w_pend_addr;

  int vectors;
  int miscompares;
  int cyc;
  int lat;
  logic [35:0] mq_addr[$];
  int          mq_due[$];

  fetch_stage #(.PC_W(36), .INST_W(32), .RESET_PC(36'h0), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .f_valid(f_valid), .f_inst(f_inst), .f_pc(f_pc), .f_pc_plus_4(f_pc_plus_4),
    .d_ready(d_ready)
  );

  fetch_stage #(.PC_W(36), .INST_W(32), .RESET_PC(36'hF_FFFF_FFFC), .DEPTH(4)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
    .imem_req_addr(w_req_addr),
    .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .f_valid(w_f_valid), .f_inst(w_f_inst), .f_pc(w_f_pc), .f_pc_plus_4(w_f_pc_plus_4),
    .d_ready(w_d_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [35:0] a);
    return a[31:0] ^ 32'h5A5A_0000;
  endfunction

  // Memory for the main instance: responses in order, lat cycles after accept
  always @(posedge clk) begin
    cyc = cyc + 1;
    #2;
    imem_resp_valid = 1'b0;
    if (rst) begin
      mq_addr.delete();
      mq_due.delete();
    end else begin
      if (mq_due.size() > 0 && mq_due[0] == cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = word(mq_addr[0]);
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(cyc + lat);
      end
    end
  end

  // Memory for the wrap instance: always ready, latency 1
  always @(posedge clk) begin
    #2;
    w_resp_valid = w_pend && !rst;
    w_resp_data  = word(w_pend_addr);
    w_pend       = w_req_valid && !rst;
    w_pend_addr  = w_req_addr;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    step();
    rst = 1'b1; lat = l; redirect_valid = 1'b0; d_ready = 1'b1; imem_req_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; lat = 1;
    rst = 1'b1; imem_req_ready = 1'b1; d_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_resp_valid = 1'b0; imem_resp_data = '0;
    w_req_ready = 1'b1; w_redirect_valid = 1'b0; w_redirect_pc = '0; w_d_ready = 1'b1;
    w_resp_valid = 1'b0; w_resp_data = '0; w_pend = 1'b0; w_pend_addr = '0;

    // Reset, L=1, free-running stream; wrap instance runs alongside
    step(); #3;
    chk("rst_req_valid", imem_req_valid, 0);
    step(); #3;
    chk("rst_f_valid", f_valid, 0);
    chk("rst_req_valid2", imem_req_valid, 0);
    step(); rst = 1'b0; #3;                       // cycle 0
    chk("c0_req_valid", imem_req_valid, 0);
    chk("c0_f_valid", f_valid, 0);
    chk("c0_f_pc", f_pc, 0);
    chk("c0_f_inst", f_inst, 0);
    chk("c0_f_pc4", f_pc_plus_4, 0);
    chk("w_c0_req_valid", w_req_valid, 0);
    chk("w_c0_addr", w_req_addr, 36'hF_FFFF_FFFC);
    step(); #3;                                   // cycle 1
    chk("c1_req_valid", imem_req_valid, 1);
    chk("c1_addr", imem_req_addr, 36'h0);
    chk("w_c1_req_valid", w_req_valid, 1);
    step(); #3;                                   // cycle 2
    chk("c2_addr", imem_req_addr, 36'h4);
    chk("c2_f_valid", f_valid, 0);
    chk("w_c2_addr_wrap", w_req_addr, 36'h0);
    step(); #3;                                   // cycle 3
    chk("c3_f_valid", f_valid, 1);
    chk("c3_f_pc", f_pc, 36'h0);
    chk("c3_f_pc4", f_pc_plus_4, 36'h4);
    chk("c3_f_inst", f_inst, word(36'h0));
    chk("c3_addr", imem_req_addr, 36'h8);
    chk("w_c3_f_valid", w_f_valid, 1);
    chk("w_c3_f_pc", w_f_pc, 36'hF_FFFF_FFFC);
    chk("w_c3_f_pc4_wrap", w_f_pc_plus_4, 36'h0);
    chk("w_c3_f_inst", w_f_inst, word(36'hF_FFFF_FFFC));
    step(); #3;                                   // cycle 4
    chk("c4_f_pc", f_pc, 36'h4);
    chk("c4_f_pc4", f_pc_plus_4, 36'h8);
    chk("w_c4_f_pc", w_f_pc, 36'h0);
    step(); #3;                                   // cycle 5
    chk("c5_f_pc", f_pc, 36'h8);
    chk("c5_f_pc4", f_pc_plus_4, 36'hC);
    chk("c5_f_inst", f_inst, word(36'h8));

    // Decode stall for 10 cycles: buffer fills, requests stop
    step(); d_ready = 1'b0; #3;                   // cycle 6
    chk("c6_f_pc", f_pc, 36'hC);
    step(); #3;                                   // cycle 7
    chk("c7_req_valid", imem_req_valid, 1);
    step(); #3;                                   // cycle 8
    chk("c8_req_full", imem_req_valid, 0);
    for (int i = 9; i <= 15; i++) begin
      step(); #3;
      chk("stall_f_valid", f_valid, 1);
      chk("stall_f_pc", f_pc, 36'hC);
      chk("stall_f_inst", f_inst, word(36'hC));
      chk("stall_req_valid", imem_req_valid, 0);
    end
    step(); d_ready = 1'b1; #3;                   // cycle 16
    chk("c16_f_pc", f_pc, 36'hC);
    chk("c16_req_valid", imem_req_valid, 0);
    step(); #3;                                   // cycle 17
    chk("c17_f_pc", f_pc, 36'h10);
    chk("c17_req_valid", imem_req_valid, 1);
    chk("c17_addr", imem_req_addr, 36'h1C);
    step(); #3;
    chk("c18_f_pc", f_pc, 36'h14);
    step(); #3;
    chk("c19_f_pc", f_pc, 36'h18);
    step(); #3;
    chk("c20_f_pc", f_pc, 36'h1C);
    chk("c20_f_inst", f_inst, word(36'h1C));

    // Mid-stream reset, then L=3 redirect with 3 reads in flight
    do_reset(3); #3;
    chk("t3_c0_f_valid", f_valid, 0);
    chk("t3_c0_f_pc", f_pc, 0);
    chk("t3_c0_req_valid", imem_req_valid, 0);
    step(); #3;
    step(); #3;
    step(); redirect_valid = 1'b1; redirect_pc = 36'h100; #3;   // cycle 3
    chk("t3_c3_addr", imem_req_addr, 36'h8);
    step(); redirect_valid = 1'b0; #3;                          // cycle 4
    chk("t3_c4_addr", imem_req_addr, 36'h100);
    chk("t3_c4_f_valid", f_valid, 0);
    for (int i = 5; i <= 7; i++) begin
      step(); #3;
      chk("t3_no_stale", f_valid, 0);
    end
    step(); #3;                                                 // cycle 8
    chk("t3_c8_f_valid", f_valid, 1);
    chk("t3_c8_f_pc", f_pc, 36'h100);
    chk("t3_c8_f_inst", f_inst, word(36'h100));
    step(); #3;
    chk("t3_c9_f_pc", f_pc, 36'h104);
    step(); #3;
    chk("t3_c10_f_pc", f_pc, 36'h108);
    step(); #3;
    chk("t3_c11_f_pc", f_pc, 36'h10C);

    // L=2: redirect in the same cycle as a response and an accept
    do_reset(2); #3;
    step(); #3;
    step(); #3;
    step(); redirect_valid = 1'b1; redirect_pc = 36'h2A0; #3;   // cycle 3
    chk("t4_c3_req_valid", imem_req_valid, 1);
    chk("t4_c3_addr", imem_req_addr, 36'h8);
    step(); redirect_valid = 1'b0; #3;                          // cycle 4
    chk("t4_c4_addr", imem_req_addr, 36'h2A0);
    chk("t4_c4_f_valid", f_valid, 0);
    step(); #3;
    chk("t4_c5_f_valid", f_valid, 0);
    step(); #3;
    chk("t4_c6_f_valid", f_valid, 0);
    step(); #3;                                                 // cycle 7
    chk("t4_c7_f_valid", f_valid, 1);
    chk("t4_c7_f_pc", f_pc, 36'h2A0);
    chk("t4_c7_f_inst", f_inst, word(36'h2A0));
    step(); #3;
    chk("t4_c8_f_pc", f_pc, 36'h2A4);

    // Back-to-back redirects with reads in flight: the last one wins
    do_reset(2); #3;
    step(); #3;
    step(); redirect_valid = 1'b1; redirect_pc = 36'h500; #3;   // cycle 2
    step(); redirect_pc = 36'h600; #3;                          // cycle 3
    chk("t7_c3_addr", imem_req_addr, 36'h500);
    step(); redirect_valid = 1'b0; #3;                          // cycle 4
    chk("t7_c4_addr", imem_req_addr, 36'h600);
    step(); #3;
    chk("t7_c5_f_valid", f_valid, 0);
    step(); #3;
    chk("t7_c6_f_valid", f_valid, 0);
    step(); #3;
    chk("t7_c7_f_pc", f_pc, 36'h600);
    step(); #3;
    chk("t7_c8_f_pc", f_pc, 36'h604);

    // Memory not ready: address held, then moved by a misaligned redirect
    do_reset(1); imem_req_ready = 1'b0; #3;
    step(); redirect_valid = 1'b1; redirect_pc = 36'h40; #3;    // cycle 1
    chk("t5_c1_addr", imem_req_addr, 36'h0);
    for (int i = 2; i <= 6; i++) begin
      step();
      redirect_valid = (i == 6);
      redirect_pc = (i == 6) ? 36'h203 : 36'h40;
      #3;
      chk("t5_hold_valid", imem_req_valid, 1);
      chk("t5_hold_addr", imem_req_addr, 36'h40);
    end
    step(); redirect_valid = 1'b0; #3;                          // cycle 7
    chk("t5_c7_addr", imem_req_addr, 36'h200);
    step(); #3;
    chk("t5_c8_addr", imem_req_addr, 36'h200);
    chk("t5_c8_f_valid", f_valid, 0);
    step(); imem_req_ready = 1'b1; #3;                          // cycle 9
    step(); #3;
    chk("t5_c10_addr", imem_req_addr, 36'h204);
    step(); #3;
    chk("t5_c11_f_pc", f_pc, 36'h200);
    chk("t5_c11_f_pc4", f_pc_plus_4, 36'h204);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
